ofm_csum_insert: RTL and testbench
==================================

Name: ofm_csum_insert

Overview:
- Single-clock, store-and-forward TX checksum offload engine for the mm2s side of the 10G Ethernet TX path.
- Per frame it accepts one control word and one data frame. It buffers the frame and computes the 16-bit ones-complement checksum from a programmable byte offset. On replay it inserts the checksum at a programmable byte offset.
- It is a parametrised successor to the split in-FSM/csum/fifo arrangement:
  - data width is configurable;
  - buffer depth is configurable;
  - insertion happens inside the block;
  - oversize frames are dropped and counted.

Parameters:
C_DATA_WIDTH, 64, stream data width in bits; allowed values 64 or 128.
C_DEPTH, 1024, frame buffer depth in data words; power of two.
C_CNT_WIDTH, 16, width of the statistic counters.

Ports:
mm2s_clk  in  1  sole clock
sys_rst  in  1  synchronous, active-high reset
s_ctrl_tdata  in  49  [15:0] cs_begin byte offset; [31:16] cs_insert byte offset; [47:32] cs_init; [48] cs_en
s_ctrl_tvalid  in  1  control word valid
s_ctrl_tready  out  1  control word accepted
s_tdata  in  C_DATA_WIDTH  frame data; byte 0 is at [7:0]
s_tkeep  in  C_DATA_WIDTH/8  byte enables; contiguous from bit 0
s_tlast  in  1  last beat of frame
s_tvalid  in  1  data valid
s_tready  out  1  data accepted
m_tdata  out  C_DATA_WIDTH  output data
m_tkeep  out  C_DATA_WIDTH/8  output byte enables
m_tlast  out  1  output last beat
m_tvalid  out  1  output valid
m_tready  in  1  downstream ready
drop_cnt  out  C_CNT_WIDTH  oversize frames dropped; saturating
ins_err_cnt  out  C_CNT_WIDTH  frames whose cs_insert+1 >= frame length; saturating
fsm_dbg  out  4  current state encoding

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. sys_rst mid-frame aborts the frame. Buffered data is discarded and not emitted. Upstream must restart from a control word.
- Handshake rules: AXI-Stream. A transfer occurs on tvalid&tready. m_* stay stable while m_tvalid=1 and m_tready=0.
- State IDLE:
  - s_ctrl_tready=1, s_tready=0.
  - On ctrl handshake: latch the fields, clear the accumulator and word count, go to FILL.
- State FILL:
  - s_tready=1.
  - Each beat is written to the buffer at wr_ptr; wr_ptr increments.
  - Each byte with index >= cs_begin and keep=1 is added as part of 16-bit big-endian words: even byte = high, odd byte = low. A trailing odd byte is padded with a zero low byte.
  - Per-beat partial sum: adder tree, 32-bit accumulator.
  - tlast -> FOLD.
  - A beat arriving while wr_ptr==C_DEPTH-1 without tlast -> DROP.
  - A frame of exactly C_DEPTH words is accepted.
- State DROP:
  - s_tready=1; beats are discarded.
  - On tlast: drop_cnt+1 (saturating), go to IDLE. Nothing is emitted.
- State FOLD (2 cycles):
  - Cycle 1: acc = acc + cs_init, then end-around carry fold to 17 bits.
  - Cycle 2: second fold to 16 bits; csum = ~folded.
  - If cs_en=0, or cs_insert+1 >= frame byte length, no insertion is made. In the length-error case only, ins_err_cnt+1.
  - Then go to DRAIN.
- State DRAIN:
  - Read the buffer from 0; 1-cycle RAM read latency, hidden by a 1-deep prefetch register. The first m_tvalid appears 1 cycle after entering DRAIN.
  - Output beats are identical to input beats. The exceptions are bytes cs_insert and cs_insert+1, which are replaced by csum[15:8] and csum[7:0]. The two bytes may straddle a beat boundary.
  - With m_tready held 1, one beat per cycle.
  - tlast handshake -> IDLE.
- Latency: from s_tlast to first m_tvalid is 3 cycles (FOLD 2 + read 1).
- Throughput: one frame in flight; no input is accepted during FOLD/DRAIN.
- Odd cs_begin is legal: summing starts at that byte, treated as a high byte.
- Zero-beat frames cannot occur, since tlast defines length.

Decomposition:
- Package ofm_pkg:
  - state enum (IDLE=0, FILL=1, DROP=2, FOLD=3, DRAIN=4);
  - ctrl field bit positions;
  - a function for keep-masked, offset-masked partial sum per beat.
- Sub-module ofm_sdp_ram: simple dual-port RAM, C_DEPTH x (C_DATA_WIDTH + C_DATA_WIDTH/8 + 1), registered read.

Test Plan:
- C_DATA_WIDTH=64, 60-byte frame of bytes 0x00..0x3B, cs_begin=34, cs_insert=50, cs_init=0x0000, cs_en=1, m_tready=1 -> 8 beats out. Bytes 50/51 hold the complement of the ones-complement sum of bytes 34..59. First m_tvalid is 3 cycles after s_tlast.
- Same frame with cs_en=0 -> output byte-identical to input; ins_err_cnt stays 0.
- 61-byte frame (odd tail), cs_begin=0, cs_init=0xFFFF -> checksum includes byte 60 as a high byte padded with 0x00. Output beat 8 has tkeep=0x1F.
- cs_insert=7 with C_DATA_WIDTH=64 -> byte 7 of beat 0 = csum[15:8] and byte 0 of beat 1 = csum[7:0].
- C_DEPTH=16: a 17-beat frame -> no output, drop_cnt=1. The next 16-beat frame is emitted intact.
- Random m_tready (50%) plus sys_rst asserted mid-DRAIN -> m_tvalid=0 the next cycle. The next frame is emitted correctly and the counters read 0.

Source files
------------

// File: rtl/ofm_pkg.sv
// Shared types and helpers for the TX checksum insertion engine.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package ofm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_DROP  = 3'd2,
    ST_FOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  // Control word layout.
  localparam int CTRL_W        = 49;
  localparam int CS_BEGIN_LSB  = 0;
  localparam int CS_INSERT_LSB = 16;
  localparam int CS_INIT_LSB   = 32;
  localparam int CS_EN_BIT     = 48;

  typedef struct packed {
    logic        cs_en;
    logic [15:0] cs_init;
    logic [15:0] cs_insert;
    logic [15:0] cs_begin;
  } ctrl_t;

  // Checksum contribution of one beat. Bytes are taken only when kept and at
  // or beyond cs_begin; a byte whose distance from cs_begin is even is the
  // high half of a 16-bit word, so an odd cs_begin and a trailing odd byte
  // both fall out naturally. Callers zero-extend narrower beats.
  function automatic logic [31:0] beat_psum(input logic [127:0] dat,
                                            input logic [15:0]  keep,
                                            input logic [31:0]  base,
                                            input logic [15:0]  cs_begin);
    logic [31:0] s;
    logic [31:0] g;
    s = '0;
    for (int i = 0; i < 16; i++) begin
      g = base + 32'(i);
      if (keep[i] && (g >= {16'd0, cs_begin})) begin
        if (g[0] == cs_begin[0]) s = s + {16'd0, dat[8*i +: 8], 8'd0};
        else                     s = s + {24'd0, dat[8*i +: 8]};
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/ofm_sdp_ram.sv
// Simple dual-port frame buffer: one write port, one read port with registered output.
// Latency: read data valid the cycle after rd_en; output holds while rd_en is low.
// Backpressure: none; the caller gates rd_en to stall the read register.
module ofm_sdp_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 73,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_dat_q, rd_dat_d;

  // Buffer write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  // Read register only advances on rd_en so a stalled consumer sees stable data.
  always_comb begin
    rd_dat_d = rd_dat_q;
    if (rd_en) rd_dat_d = mem[rd_addr];
  end

  // Read data register.
  always_ff @(posedge clk) begin
    rd_dat_q <= rd_dat_d;
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/ofm_csum_insert.sv
// Store-and-forward TX checksum offload: buffer a frame, sum it, replay it with the checksum inserted.
// Latency: first output beat 3 cycles after the input tlast handshake (2 fold + 1 RAM read).
// Backpressure: one frame in flight; input stalls during FOLD/DRAIN, output holds while m_tready=0.
module ofm_csum_insert
  import ofm_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int C_DEPTH      = 1024,
  parameter int C_CNT_WIDTH  = 16
) (
  input  logic                      mm2s_clk,
  input  logic                      sys_rst,
  input  logic [CTRL_W-1:0]         s_ctrl_tdata,
  input  logic                      s_ctrl_tvalid,
  output logic                      s_ctrl_tready,
  input  logic [C_DATA_WIDTH-1:0]   s_tdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                      s_tlast,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  output logic [C_DATA_WIDTH-1:0]   m_tdata,
  output logic [C_DATA_WIDTH/8-1:0] m_tkeep,
  output logic                      m_tlast,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [C_CNT_WIDTH-1:0]    drop_cnt,
  output logic [C_CNT_WIDTH-1:0]    ins_err_cnt,
  output logic [3:0]                fsm_dbg
);

  localparam int NB = C_DATA_WIDTH / 8;
  localparam int AW = $clog2(C_DEPTH);
  localparam int RW = C_DATA_WIDTH + NB + 1;
  localparam logic [AW:0] LAST_WORD = (AW+1)'(C_DEPTH - 1);
  localparam logic [AW:0] ONE_W     = (AW+1)'(1);
  localparam logic [C_CNT_WIDTH-1:0] ONE_C = C_CNT_WIDTH'(1);

  state_e                 state_q, state_d;
  ctrl_t                  ctrl_q, ctrl_d;
  logic [31:0]            acc_q, acc_d;
  logic [31:0]            len_q, len_d;
  logic [AW:0]            wcnt_q, wcnt_d;
  logic                   fold_ph_q, fold_ph_d;
  logic [16:0]            fold_q, fold_d;
  logic [15:0]            csum_q, csum_d;
  logic                   ins_en_q, ins_en_d;
  logic [AW:0]            rd_ptr_q, rd_ptr_d;
  logic [AW:0]            oidx_q, oidx_d;
  logic                   dvld_q, dvld_d;
  logic [C_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic [C_CNT_WIDTH-1:0] ins_err_cnt_q, ins_err_cnt_d;

  logic          ram_we, ram_re;
  logic [RW-1:0] ram_rd;
  logic [31:0]   beat_base, beat_sum, beat_bytes;
  logic [31:0]   init_sum;
  logic [15:0]   fold16;
  logic          len_err;

  ofm_sdp_ram #(
    .DEPTH (C_DEPTH),
    .WIDTH (RW),
    .AW    (AW)
  ) u_ram (
    .clk     (mm2s_clk),
    .wr_en   (ram_we),
    .wr_addr (wcnt_q[AW-1:0]),
    .wr_dat  ({s_tlast, s_tkeep, s_tdata}),
    .rd_en   (ram_re),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_dat  (ram_rd)
  );

  // Checksum contribution and byte count of the beat currently on s_*.
  always_comb begin
    beat_base  = 32'(wcnt_q) * 32'(NB);
    beat_sum   = beat_psum(128'(s_tdata), 16'(s_tkeep), beat_base, ctrl_q.cs_begin);
    beat_bytes = '0;
    for (int i = 0; i < NB; i++) beat_bytes = beat_bytes + 32'(s_tkeep[i]);
  end

  // Fold arithmetic and insertion-range check used by the FOLD state.
  always_comb begin
    init_sum = acc_q + {16'd0, ctrl_q.cs_init};
    fold16   = fold_q[15:0] + {15'd0, fold_q[16]};
    len_err  = ({16'd0, ctrl_q.cs_insert} + 32'd1) >= len_q;
  end

  // Next-state logic and handshakes for fill, drop, fold and drain.
  always_comb begin
    state_d       = state_q;
    ctrl_d        = ctrl_q;
    acc_d         = acc_q;
    len_d         = len_q;
    wcnt_d        = wcnt_q;
    fold_ph_d     = fold_ph_q;
    fold_d        = fold_q;
    csum_d        = csum_q;
    ins_en_d      = ins_en_q;
    rd_ptr_d      = rd_ptr_q;
    oidx_d        = oidx_q;
    dvld_d        = dvld_q;
    drop_cnt_d    = drop_cnt_q;
    ins_err_cnt_d = ins_err_cnt_q;
    s_ctrl_tready = 1'b0;
    s_tready      = 1'b0;
    ram_we        = 1'b0;
    ram_re        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        s_ctrl_tready = ~sys_rst;
        if (s_ctrl_tvalid && !sys_rst) begin
          ctrl_d.cs_begin  = s_ctrl_tdata[CS_BEGIN_LSB  +: 16];
          ctrl_d.cs_insert = s_ctrl_tdata[CS_INSERT_LSB +: 16];
          ctrl_d.cs_init   = s_ctrl_tdata[CS_INIT_LSB   +: 16];
          ctrl_d.cs_en     = s_ctrl_tdata[CS_EN_BIT];
          acc_d            = '0;
          len_d            = '0;
          wcnt_d           = '0;
          state_d          = ST_FILL;
        end
      end
      ST_FILL: begin
        s_tready = 1'b1;
        if (s_tvalid) begin
          ram_we = 1'b1;
          acc_d  = acc_q + beat_sum;
          len_d  = len_q + beat_bytes;
          wcnt_d = wcnt_q + ONE_W;
          if (s_tlast) begin
            fold_ph_d = 1'b0;
            state_d   = ST_FOLD;
          end else if (wcnt_q == LAST_WORD) begin
            // Buffer is full and the frame keeps going: discard the rest.
            state_d = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        s_tready = 1'b1;
        if (s_tvalid && s_tlast) begin
          if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + ONE_C;
          state_d = ST_IDLE;
        end
      end
      ST_FOLD: begin
        if (!fold_ph_q) begin
          fold_d    = {1'b0, init_sum[15:0]} + {1'b0, init_sum[31:16]};
          fold_ph_d = 1'b1;
        end else begin
          csum_d   = ~fold16;
          ins_en_d = ctrl_q.cs_en && !len_err;
          if (ctrl_q.cs_en && len_err && (ins_err_cnt_q != '1))
            ins_err_cnt_d = ins_err_cnt_q + ONE_C;
          rd_ptr_d = '0;
          dvld_d   = 1'b0;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The RAM read register doubles as the output stage; a new read is
        // issued only when that register is empty or being consumed.
        if (dvld_q && m_tready && ram_rd[RW-1]) begin
          dvld_d  = 1'b0;
          state_d = ST_IDLE;
        end else if ((rd_ptr_q != wcnt_q) && (!dvld_q || m_tready)) begin
          ram_re   = 1'b1;
          rd_ptr_d = rd_ptr_q + ONE_W;
          oidx_d   = rd_ptr_q;
          dvld_d   = 1'b1;
        end else if (dvld_q && m_tready) begin
          dvld_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge mm2s_clk) begin
    if (sys_rst) begin
      state_q       <= ST_IDLE;
      ctrl_q        <= '0;
      acc_q         <= '0;
      len_q         <= '0;
      wcnt_q        <= '0;
      fold_ph_q     <= 1'b0;
      fold_q        <= '0;
      csum_q        <= '0;
      ins_en_q      <= 1'b0;
      rd_ptr_q      <= '0;
      oidx_q        <= '0;
      dvld_q        <= 1'b0;
      drop_cnt_q    <= '0;
      ins_err_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      ctrl_q        <= ctrl_d;
      acc_q         <= acc_d;
      len_q         <= len_d;
      wcnt_q        <= wcnt_d;
      fold_ph_q     <= fold_ph_d;
      fold_q        <= fold_d;
      csum_q        <= csum_d;
      ins_en_q      <= ins_en_d;
      rd_ptr_q      <= rd_ptr_d;
      oidx_q        <= oidx_d;
      dvld_q        <= dvld_d;
      drop_cnt_q    <= drop_cnt_d;
      ins_err_cnt_q <= ins_err_cnt_d;
    end
  end

  // Output beat: buffered data with the two checksum bytes substituted; zero when idle.
  always_comb begin
    logic [31:0] g;
    logic [7:0]  b;
    g       = '0;
    b       = '0;
    m_tdata = '0;
    for (int i = 0; i < NB; i++) begin
      g = 32'(oidx_q) * 32'(NB) + 32'(i);
      b = ram_rd[8*i +: 8];
      if (ins_en_q && (g == {16'd0, ctrl_q.cs_insert}))               b = csum_q[15:8];
      else if (ins_en_q && (g == ({16'd0, ctrl_q.cs_insert} + 32'd1))) b = csum_q[7:0];
      m_tdata[8*i +: 8] = dvld_q ? b : 8'h00;
    end
  end

  assign m_tkeep     = dvld_q ? ram_rd[C_DATA_WIDTH +: NB] : '0;
  assign m_tlast     = dvld_q & ram_rd[RW-1];
  assign m_tvalid    = dvld_q;
  assign drop_cnt    = drop_cnt_q;
  assign ins_err_cnt = ins_err_cnt_q;
  assign fsm_dbg     = {1'b0, state_q};

endmodule

// File: tb/tb_ofm_csum_insert.sv
// Directed bench for the checksum insertion engine with a scoreboard of expected output beats.
// Latency: checks first output 3 cycles after input tlast.
// Backpressure: exercises constant and random m_tready, including reset mid-drain.
module tb_ofm_csum_insert;

  localparam int DW = 64;
  localparam int NB = 8;
  localparam int DEPTH = 16;
  localparam int CW = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [NB-1:0] k;
    logic          l;
  } beat_t;

  logic          clk;
  logic          sys_rst;
  logic [48:0]   s_ctrl_tdata;
  logic          s_ctrl_tvalid;
  logic          s_ctrl_tready;
  logic [DW-1:0] s_tdata;
  logic [NB-1:0] s_tkeep;
  logic          s_tlast;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [NB-1:0] m_tkeep;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] ins_err_cnt;
  logic [3:0]    fsm_dbg;

  beat_t      exp_q[$];
  logic [7:0] fb [256];
  int         n_cmp;
  int         n_err;
  int         cyc;
  int         lat_base;
  bit         rnd_mode;

  ofm_csum_insert #(
    .C_DATA_WIDTH (DW),
    .C_DEPTH      (DEPTH),
    .C_CNT_WIDTH  (CW)
  ) dut (
    .mm2s_clk      (clk),
    .sys_rst       (sys_rst),
    .s_ctrl_tdata  (s_ctrl_tdata),
    .s_ctrl_tvalid (s_ctrl_tvalid),
    .s_ctrl_tready (s_ctrl_tready),
    .s_tdata       (s_tdata),
    .s_tkeep       (s_tkeep),
    .s_tlast       (s_tlast),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .m_tdata       (m_tdata),
    .m_tkeep       (m_tkeep),
    .m_tlast       (m_tlast),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .drop_cnt      (drop_cnt),
    .ins_err_cnt   (ins_err_cnt),
    .fsm_dbg       (fsm_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference checksum: walk 16-bit big-endian words from cs_begin, then fold.
  function automatic logic [15:0] model_csum(input logic [15:0] cb, input logic [15:0] init, input int nb);
    logic [31:0] s;
    s = {16'd0, init};
    for (int j = int'(cb); j < nb; j += 2)
      s = s + {16'd0, fb[j], ((j + 1) < nb) ? fb[j+1] : 8'h00};
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    return ~s[15:0];
  endfunction

  task automatic fill_seq(input int n);
    for (int i = 0; i < 256; i++) fb[i] = (i < n) ? 8'(i) : 8'h00;
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < 256; i++) fb[i] = (i < n) ? 8'($urandom_range(0, 255)) : 8'h00;
  endtask

  task automatic send_frame(input logic [15:0] cb, input logic [15:0] ci, input logic [15:0] init,
                            input logic en, input int nb, input bit exp_out);
    logic [7:0]  ob [256];
    logic [15:0] cs;
    beat_t       e;
    int          nbeats;
    int          idx;
    bit          ok;
    cs = model_csum(cb, init, nb);
    for (int i = 0; i < 256; i++) ob[i] = fb[i];
    if (en && ((int'(ci) + 1) < nb)) begin
      ob[int'(ci)]     = cs[15:8];
      ob[int'(ci) + 1] = cs[7:0];
    end
    nbeats = (nb + NB - 1) / NB;
    if (exp_out) begin
      for (int b = 0; b < nbeats; b++) begin
        e = '0;
        for (int i = 0; i < NB; i++) begin
          idx = b * NB + i;
          e.d[8*i +: 8] = (idx < nb) ? ob[idx] : 8'h00;
          e.k[i]        = (idx < nb);
        end
        e.l = (b == nbeats - 1);
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    s_ctrl_tdata  = {en, init, ci, cb};
    s_ctrl_tvalid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (s_ctrl_tready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("ctrl_ready_wait", 128'(ok), 128'd1);
    @(posedge clk); #1;
    s_ctrl_tvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      for (int i = 0; i < NB; i++) begin
        idx = b * NB + i;
        s_tdata[8*i +: 8] = (idx < nb) ? fb[idx] : 8'h00;
        s_tkeep[i]        = (idx < nb);
      end
      s_tlast  = (b == nbeats - 1);
      s_tvalid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        if (s_tready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("data_ready_wait", 128'(ok), 128'd1);
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    lat_base = cyc;
  endtask

  task automatic wait_empty(input string tag);
    for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(negedge clk);
    chk(tag, 128'(exp_q.size()), 128'd0);
    repeat (2) @(negedge clk);
    chk({tag, "_idle"}, 128'(fsm_dbg), 128'd0);
  endtask

  // Scoreboard consumer plus hold-while-stalled check on the output stream.
  task automatic monitor();
    beat_t cur, prev_beat, e;
    bit    prev_stall;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (sys_rst) begin
        prev_stall = 1'b0;
      end else begin
        cur = {m_tdata, m_tkeep, m_tlast};
        if (prev_stall) chk("hold_stable", 128'({m_tvalid, cur}), 128'({1'b1, prev_beat}));
        if (m_tvalid && m_tready) begin
          chk("beat_expected", 128'(exp_q.size() != 0), 128'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_beat", 128'(cur), 128'(e));
          end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_beat  = cur;
      end
    end
  endtask

  task automatic rdy_gen();
    forever begin
      @(posedge clk); #1;
      m_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic watchdog();
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within 60000 cycles");
    $fatal(1, "watchdog expired");
  endtask

  initial begin
    int lat;
    n_cmp         = 0;
    n_err         = 0;
    rnd_mode      = 1'b0;
    sys_rst       = 1'b1;
    s_ctrl_tdata  = '0;
    s_ctrl_tvalid = 1'b0;
    s_tdata       = '0;
    s_tkeep       = '0;
    s_tlast       = 1'b0;
    s_tvalid      = 1'b0;
    m_tready      = 1'b1;
    fork
      monitor();
      rdy_gen();
      watchdog();
    join_none

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", 128'(m_tvalid), 128'd0);
    chk("rst_m_beat", 128'({m_tdata, m_tkeep, m_tlast}), 128'd0);
    chk("rst_ready", 128'({s_ctrl_tready, s_tready}), 128'd0);
    chk("rst_counters", 128'({drop_cnt, ins_err_cnt}), 128'd0);
    chk("rst_state", 128'(fsm_dbg), 128'd0);
    @(posedge clk); #1;
    sys_rst = 1'b0;
    @(negedge clk);
    chk("idle_ctrl_ready", 128'(s_ctrl_tready), 128'd1);

    // 60-byte frame, sum from 34, insert at 50; first output 3 cycles after tlast.
    fill_seq(60);
    send_frame(16'd34, 16'd50, 16'h0000, 1'b1, 60, 1'b1);
    lat = -1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (m_tvalid) begin lat = cyc - lat_base; break; end
    end
    chk("first_vld_latency", 128'(lat), 128'd3);
    wait_empty("frame_ins50");
    chk("ins_err_after_ok", 128'(ins_err_cnt), 128'd0);

    // Same frame with insertion disabled passes through untouched.
    send_frame(16'd34, 16'd50, 16'h0000, 1'b0, 60, 1'b1);
    wait_empty("frame_noins");
    chk("ins_err_cs_en0", 128'(ins_err_cnt), 128'd0);

    // Odd-length frame with odd tail byte and cs_init=0xFFFF.
    fill_seq(61);
    send_frame(16'd0, 16'd20, 16'hFFFF, 1'b1, 61, 1'b1);
    wait_empty("frame_odd61");

    // Checksum straddling beat 0 / beat 1.
    fill_rand(40);
    send_frame(16'd0, 16'd7, 16'h0000, 1'b1, 40, 1'b1);
    wait_empty("frame_straddle");

    // Odd cs_begin.
    fill_rand(45);
    send_frame(16'd13, 16'd2, 16'h0A0B, 1'b1, 45, 1'b1);
    wait_empty("frame_oddbegin");

    // Insert offset at the last legal position, then one past it.
    fill_rand(60);
    send_frame(16'd0, 16'd58, 16'h0000, 1'b1, 60, 1'b1);
    wait_empty("frame_ins58");
    chk("ins_err_edge_ok", 128'(ins_err_cnt), 128'd0);
    send_frame(16'd0, 16'd59, 16'h0000, 1'b1, 60, 1'b1);
    wait_empty("frame_ins59");
    chk("ins_err_edge_bad", 128'(ins_err_cnt), 128'd1);

    // Oversize frame is dropped; a full-depth frame is kept.
    fill_rand(DEPTH * NB + NB);
    send_frame(16'd0, 16'd10, 16'h0000, 1'b1, DEPTH * NB + NB, 1'b0);
    repeat (5) @(negedge clk);
    chk("drop_cnt_one", 128'(drop_cnt), 128'd1);
    chk("drop_back_idle", 128'(fsm_dbg), 128'd0);
    fill_rand(DEPTH * NB);
    send_frame(16'd0, 16'd10, 16'h0000, 1'b0, DEPTH * NB, 1'b1);
    wait_empty("frame_full_depth");

    // Random backpressure, reset in the middle of the drain.
    rnd_mode = 1'b1;
    fill_rand(100);
    send_frame(16'd14, 16'd40, 16'h1234, 1'b1, 100, 1'b1);
    for (int t = 0; t < 50 && fsm_dbg != 4'd4; t++) @(negedge clk);
    chk("reach_drain", 128'(fsm_dbg), 128'd4);
    repeat (3) @(posedge clk);
    #1 sys_rst = 1'b1;
    @(posedge clk); #1;
    sys_rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_drain_vld", 128'(m_tvalid), 128'd0);
    chk("rst_mid_drain_state", 128'(fsm_dbg), 128'd0);
    chk("rst_mid_drain_cnt", 128'({drop_cnt, ins_err_cnt}), 128'd0);
    exp_q.delete();
    fill_rand(77);
    send_frame(16'd3, 16'd30, 16'h0001, 1'b1, 77, 1'b1);
    wait_empty("frame_after_rst");
    rnd_mode = 1'b0;
    fill_seq(61);
    send_frame(16'd34, 16'd50, 16'h0000, 1'b1, 61, 1'b1);
    wait_empty("frame_final");
    chk("final_counters", 128'({drop_cnt, ins_err_cnt}), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
